// File: rtl/mont_conv_stream.sv
// ---------------------------------------------------------------------------
// mont_conv_stream
//
// Streaming Montgomery-domain converter for the NTT datapath.
//   in_mode = 0 : out = x * R mod Q      (into Montgomery form)
//   in_mode = 1 : out = x * R^-1 mod Q   (back to normal form)
// with R = 2^DATA_WIDTH. Both modes reuse one Montgomery reduction:
// mode 0 reduces x * (R^2 mod Q), mode 1 reduces x * 1.
//
// Pipeline (STAGES deep, fixed latency, global stall):
//   stage 0            : T  = x * k
//   stages 1..STAGES-2 : m  = (T * -Q^-1) mod R,  mq = m * Q   (then delay)
//   stage STAGES-1     : u  = (T + mq) / R, conditional subtract of Q
// With STAGES == 2 the reduction multiplies feed the last stage directly.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     input handshake (in_ready = !stall, combinational)
//   in_data, in_mode      coefficient and per-beat direction
//   out_valid/out_ready   output handshake
//   out_data              result in [0, Q), registered
//   out_last              high on every N-th output beat
//   busy                  any stage holds a valid beat
// ---------------------------------------------------------------------------
module mont_conv_stream #(
    parameter int          DATA_WIDTH = 23,
    parameter int unsigned Q          = 8380417,
    parameter int          STAGES     = 3,
    parameter int          N          = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
);

    localparam int TW  = 2 * DATA_WIDTH;      // product width
    localparam int SW  = TW + 1;              // T + m*Q needs one carry bit
    localparam int UW  = DATA_WIDTH + 1;      // (T + m*Q)/R < 2Q
    localparam int CW  = (N > 1) ? $clog2(N) : 1;
    localparam int MID = STAGES - 2;

    // R^2 mod Q by repeated doubling, so no wide intermediate is needed.
    function automatic logic [63:0] f_r2_mod_q();
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < 2 * DATA_WIDTH; i++) begin
            r = r << 1;
            if (r >= 64'(Q)) r = r - 64'(Q);
        end
        return r;
    endfunction

    // -Q^-1 mod 2^64 by Newton iteration; each step doubles the correct bits,
    // starting from 1 bit (Q odd), so six steps cover 64 bits.
    function automatic logic [63:0] f_neg_qinv();
        logic [63:0] inv;
        inv = 64'd1;
        for (int i = 0; i < 6; i++) begin
            inv = inv * (64'd2 - 64'(Q) * inv);
        end
        return ~inv + 64'd1;
    endfunction

    localparam logic [DATA_WIDTH-1:0] C2       = DATA_WIDTH'(f_r2_mod_q());
    localparam logic [DATA_WIDTH-1:0] QINV_NEG = DATA_WIDTH'(f_neg_qinv());
    localparam logic [UW-1:0]         Q_U      = UW'(Q);

    logic [STAGES-1:0]     r_valid;
    logic [TW-1:0]         r_t0;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [CW-1:0]         r_count;

    logic                  w_stall;
    logic                  w_out_xfer;
    logic [DATA_WIDTH-1:0] w_k;
    logic [DATA_WIDTH-1:0] w_m;
    logic [TW-1:0]         w_mq;
    logic [TW-1:0]         w_fin_t;
    logic [TW-1:0]         w_fin_mq;
    logic [SW-1:0]         w_sum;
    logic [UW-1:0]         w_u;
    logic [DATA_WIDTH-1:0] w_res;

    // Handshake: the whole pipe freezes only when the last stage cannot drain.
    assign w_stall    = r_valid[STAGES-1] && !out_ready;
    assign w_out_xfer = r_valid[STAGES-1] && out_ready;
    assign in_ready   = !w_stall;

    // Stage 0 operand: mode selects the constant multiplier per beat.
    assign w_k = in_mode ? DATA_WIDTH'(1) : C2;

    // Reduction multiplies; the DATA_WIDTH-bit product is exactly mod R.
    assign w_m  = DATA_WIDTH'(r_t0[DATA_WIDTH-1:0] * QINV_NEG);
    assign w_mq = TW'(w_m) * TW'(Q);

    // Last stage: T + m*Q is a multiple of R; the shift is exact.
    assign w_sum = SW'(w_fin_t) + SW'(w_fin_mq);
    assign w_u   = UW'(w_sum >> DATA_WIDTH);
    assign w_res = (w_u >= Q_U) ? DATA_WIDTH'(w_u - Q_U) : DATA_WIDTH'(w_u);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and the shift order inside the block is irrelevant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= '0;
            r_t0       <= '0;
            r_out_data <= '0;
            r_count    <= '0;
        end else begin
            if (!w_stall) begin
                // in_ready == !stall here, so in_valid is exactly "accepted".
                r_valid    <= {r_valid[STAGES-2:0], in_valid};
                r_t0       <= TW'(in_data) * TW'(w_k);
                r_out_data <= w_res;
            end
            if (w_out_xfer) begin
                r_count <= (r_count == CW'(N - 1)) ? '0 : r_count + CW'(1);
            end
        end
    end

    generate
        if (MID == 0) begin : g_no_mid
            assign w_fin_t  = r_t0;
            assign w_fin_mq = w_mq;
        end else begin : g_mid
            logic [TW-1:0] r_mid_t  [MID];
            logic [TW-1:0] r_mid_mq [MID];

            // NOTE: the small datapath arrays are reset too, so bubbles carry
            // zeros and out_data is deterministic right after reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < MID; i++) begin
                        r_mid_t[i]  <= '0;
                        r_mid_mq[i] <= '0;
                    end
                end else if (!w_stall) begin
                    r_mid_t[0]  <= r_t0;
                    r_mid_mq[0] <= w_mq;
                    for (int i = 1; i < MID; i++) begin
                        r_mid_t[i]  <= r_mid_t[i-1];
                        r_mid_mq[i] <= r_mid_mq[i-1];
                    end
                end
            end

            assign w_fin_t  = r_mid_t[MID-1];
            assign w_fin_mq = r_mid_mq[MID-1];
        end
    endgenerate

    assign out_valid = r_valid[STAGES-1];
    assign out_data  = r_out_data;
    assign out_last  = r_valid[STAGES-1] && (r_count == CW'(N - 1));
    assign busy      = |r_valid;

endmodule

// File: tb/tb_mont_conv_stream.sv
// ---------------------------------------------------------------------------
// tb_mont_conv_stream
//
// Self-checking bench for mont_conv_stream with default parameters.
// Reference model: plain modular arithmetic (x*R mod Q, x*R^-1 mod Q with
// R^-1 from Fermat's little theorem, Q prime) and a FIFO scoreboard of
// expected outputs; per-cycle checks on in_ready, busy, out_last, range and
// hold stability. Inputs driven at the falling edge, outputs sampled 1ns later.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mont_conv_stream;

    localparam int              DW     = 23;
    localparam int              STAGES = 3;
    localparam int              N      = 256;
    localparam int unsigned     QI     = 8380417;
    localparam longint unsigned QL     = 64'd8380417;
    localparam longint unsigned RL     = 64'd1 << DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;

    mont_conv_stream #(
        .DATA_WIDTH(DW),
        .Q         (QI),
        .STAGES    (STAGES),
        .N         (N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_mode  (in_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [DW-1:0] d;
        logic          m;
        logic [DW-1:0] exp;
    } vec_t;

    int              n_checks;
    int              n_fail;
    longint unsigned r_inv;
    logic [DW-1:0]   exp_q[$];
    logic [DW-1:0]   out_log[$];
    logic [DW-1:0]   ref_log[$];
    logic [DW-1:0]   xs[$];
    logic [DW-1:0]   st_d[$];
    logic            st_m[$];
    int              last_idx[$];
    vec_t            vecs[$];
    int              xfer_cnt;
    int              stream_cycles;
    logic            prev_stall;
    logic [DW-1:0]   prev_data;
    logic            acc;
    logic            got_out;
    logic [DW-1:0]   got_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic longint unsigned modpow(input longint unsigned b, input longint unsigned e);
        longint unsigned r;
        longint unsigned x;
        longint unsigned k;
        r = 1;
        x = b % QL;
        k = e;
        while (k != 0) begin
            if ((k & 64'd1) != 0) r = (r * x) % QL;
            x = (x * x) % QL;
            k = k >> 1;
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] model(input logic [DW-1:0] x, input logic m);
        longint unsigned xv;
        xv = 64'(x);
        if (m == 1'b0) return DW'((xv * RL) % QL);
        return DW'(((xv % QL) * r_inv) % QL);
    endfunction

    // One clock cycle: drive, settle, check invariants, run scoreboard.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic m, input logic ordy);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_mode   = m;
        out_ready = ordy;
        #1;
        acc     = 1'b0;
        got_out = 1'b0;
        check("in_ready_vs_stall", 64'(in_ready), 64'(!(out_valid && !out_ready)));
        check("busy", 64'(busy), 64'(exp_q.size() != 0));
        if (prev_stall) begin
            check("hold_valid", 64'(out_valid), 64'(1));
            check("hold_data", 64'(out_data), 64'(prev_data));
        end
        if (out_valid) check("out_range", 64'(64'(out_data) < QL), 64'(1));
        check("out_last", 64'(out_last), 64'(out_valid && (xfer_cnt % N == N - 1)));
        if (out_valid && out_ready) begin
            got_out  = 1'b1;
            got_data = out_data;
            out_log.push_back(out_data);
            check("beat_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
            if (out_last) last_idx.push_back(xfer_cnt + 1);
            xfer_cnt++;
        end
        if (in_valid && in_ready) begin
            acc = 1'b1;
            exp_q.push_back(model(d, m));
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
    endtask

    // policy 0: out_ready always high; 1: random 50% with a 10-cycle hold.
    task automatic run_stream(input int policy, input int hold_at);
        int   i;
        int   guard;
        logic r;
        i     = 0;
        guard = 0;
        while (i < st_d.size() && guard < 20000) begin
            if (policy == 0) r = 1'b1;
            else if (guard >= hold_at && guard < hold_at + 10) r = 1'b0;
            else r = ($urandom_range(0, 1) == 1);
            cycle(1'b1, st_d[i], st_m[i], r);
            if (acc) i++;
            guard++;
        end
        check("stream_complete", 64'(i), 64'(st_d.size()));
        stream_cycles = guard;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            cycle(1'b0, '0, 1'b0, 1'b1);
            g++;
        end
        check("drain_done", 64'(exp_q.size()), 64'(0));
        cycle(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_out_last"}, 64'(out_last), 64'(0));
        check({tag, "_out_data"}, 64'(out_data), 64'(0));
        check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    endtask

    task automatic clear_model();
        exp_q.delete();
        last_idx.delete();
        xfer_cnt   = 0;
        prev_stall = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        reset_checks(tag);
        clear_model();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 1'b0;
        out_ready = 1'b1;
        r_inv     = modpow(RL % QL, QL - 2);
        clear_model();

        repeat (3) @(negedge clk);
        do_reset("por");

        // Known-answer vectors, one beat at a time, with latency measurement.
        vecs.push_back('{"m0_one",   23'd1,       1'b0, 23'd8191});
        vecs.push_back('{"m0_zero",  23'd0,       1'b0, 23'd0});
        vecs.push_back('{"m0_qm1",   23'd8380416, 1'b0, 23'd8372226});
        vecs.push_back('{"m0_q",     23'd8380417, 1'b0, 23'd0});
        vecs.push_back('{"m0_wide",  23'd8388607, 1'b0, 23'd40954});
        vecs.push_back('{"m1_r",     23'd8191,    1'b1, 23'd1});
        vecs.push_back('{"m1_r2",    23'd49145,   1'b1, 23'd8191});
        vecs.push_back('{"m1_back",  23'd8372226, 1'b1, 23'd8380416});
        vecs.push_back('{"m1_zero",  23'd0,       1'b1, 23'd0});
        vecs.push_back('{"m1_wide",  23'd8388607, 1'b1, model(23'd8388607, 1'b1)});
        foreach (vecs[k]) begin
            cycle(1'b1, vecs[k].d, vecs[k].m, 1'b1);
            check({"accept_", vecs[k].name}, 64'(acc), 64'(1));
            n = 0;
            got_out = 1'b0;
            while (!got_out && n < 20) begin
                cycle(1'b0, '0, 1'b0, 1'b1);
                n++;
            end
            check({"latency_", vecs[k].name}, 64'(n), 64'(STAGES));
            check({"kat_", vecs[k].name}, 64'(got_data), 64'(vecs[k].exp));
        end
        drain();

        // Round trip: into Montgomery form and back must return x.
        xs.delete();
        xs.push_back(23'd0);
        xs.push_back(23'd1);
        xs.push_back(23'd2);
        xs.push_back(DW'(QI - 1));
        xs.push_back(DW'(QI - 2));
        for (int i = 0; i < 995; i++) xs.push_back(DW'($urandom_range(0, QI - 1)));
        st_d = xs;
        st_m.delete();
        foreach (xs[i]) st_m.push_back(1'b0);
        out_log.delete();
        run_stream(0, 0);
        check("throughput", 64'(stream_cycles), 64'(st_d.size()));
        drain();
        st_d = out_log;
        st_m.delete();
        foreach (st_d[i]) st_m.push_back(1'b1);
        out_log.delete();
        run_stream(0, 0);
        drain();
        check("roundtrip_count", 64'(out_log.size()), 64'(xs.size()));
        foreach (xs[i]) begin
            if (i < out_log.size()) check("roundtrip", 64'(out_log[i]), 64'(xs[i]));
        end

        // Backpressure: stalled run must reproduce the unstalled output sequence.
        st_d.delete();
        st_m.delete();
        for (int i = 0; i < 400; i++) begin
            st_d.push_back(DW'($urandom));
            st_m.push_back(1'($urandom_range(0, 1)));
        end
        out_log.delete();
        run_stream(0, 0);
        drain();
        ref_log = out_log;
        out_log.delete();
        run_stream(1, 50);
        drain();
        check("bp_count", 64'(out_log.size()), 64'(ref_log.size()));
        foreach (ref_log[i]) begin
            if (i < out_log.size()) check("bp_sequence", 64'(out_log[i]), 64'(ref_log[i]));
        end

        // out_last period over 600 back-to-back beats with mixed modes.
        do_reset("pre_last");
        st_d.delete();
        st_m.delete();
        for (int i = 0; i < 600; i++) begin
            st_d.push_back(DW'($urandom));
            st_m.push_back(1'($urandom_range(0, 1)));
        end
        run_stream(0, 0);
        drain();
        check("last_pulses", 64'(last_idx.size()), 64'(2));
        if (last_idx.size() >= 2) begin
            check("last_first", 64'(last_idx[0]), 64'(256));
            check("last_second", 64'(last_idx[1]), 64'(512));
        end

        // Reset with three beats in flight while stalled.
        cycle(1'b1, 23'd11, 1'b0, 1'b0);
        cycle(1'b1, 23'd22, 1'b1, 1'b0);
        cycle(1'b1, 23'd33, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        check("pre_reset_stalled", 64'(out_valid && !in_ready), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        reset_checks("midrst");
        clear_model();
        @(negedge clk);
        rst = 1'b0;
        st_d.delete();
        st_m.delete();
        for (int i = 0; i < 300; i++) begin
            st_d.push_back(DW'($urandom));
            st_m.push_back(1'($urandom_range(0, 1)));
        end
        run_stream(0, 0);
        drain();
        check("midrst_last_pulses", 64'(last_idx.size()), 64'(1));
        if (last_idx.size() >= 1) check("midrst_last_index", 64'(last_idx[0]), 64'(256));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
